io_bus_initiator: RTL and testbench
===================================

Name: io_bus_initiator

Overview:
- Master-side engine for the core's memory-mapped IO bus (wReadEnable/wWriteEnable/wByteEnable/wAddress/wWriteData/wReadData).
- Turns single or burst read/write commands into IO-bus cycles, one beat per clock.
- Lets hardware agents poll or program IO peripherals such as the stopwatch without CPU involvement.
- Sits beside the CPU's IO port; an external arbiter, outside this block, muxes the two masters.

Parameters:
- LEN_W, 4, width of cmd_len; a burst is cmd_len+1 beats, 1..2^LEN_W.
- ADDR_STEP, 4, byte increment of wAddress between beats.

Ports:
- iCLK  in  1  system clock; all state updates on rising edge.
- iRST_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  32  first beat address.
- cmd_be  in  4  byte enable, applied to every beat.
- cmd_len  in  LEN_W  beats minus one.
- wr_valid  in  1  write-data beat offered.
- wr_data  in  32  write-data beat.
- wr_ready  out  1  write beat accepted this cycle.
- rsp_valid  out  1  read-data beat held.
- rsp_data  out  32  read-data beat.
- rsp_last  out  1  marks final beat of a read burst.
- rsp_ready  in  1  consumer accepts the beat.
- busy  out  1  high whenever not IDLE.
- wReadEnable  out  1  IO bus read strobe.
- wWriteEnable  out  1  IO bus write strobe.
- wByteEnable  out  4  IO bus byte enable.
- wAddress  out  32  IO bus address.
- wWriteData  out  32  IO bus write data.
- wReadData  in  32  IO bus read data; responders drive it combinationally during wReadEnable.

Behaviour:
- Clock and reset: one clock, iCLK; reset iRST_n is asynchronous and active-low.
- Reset values: state IDLE; addr_reg 0; be_reg 0; beats_left 0; rsp_valid 0; rsp_data 0; rsp_last 0.
- Reset output values: wReadEnable 0, wWriteEnable 0, wByteEnable 0, wAddress 0, wWriteData 0, wr_ready 0, busy 0, cmd_ready 1 after reset is released.
- Reset mid-burst: the burst is abandoned immediately; no further strobes; the held response is dropped.
- Bus protocol, fixed by the IO responders:
  - Read data is combinational in the same cycle wReadEnable and wAddress are valid; the initiator captures wReadData at the rising edge ending that cycle.
  - Writes are sampled by responders at the rising edge while wWriteEnable is high.
  - Never assert wReadEnable and wWriteEnable together.
- FSM states:
  - IDLE:
    - cmd_ready=1; strobes 0; wAddress holds addr_reg.
    - On cmd_valid, load addr_reg=cmd_addr, be_reg=cmd_be, beats_left=cmd_len.
    - Go to WRITE if cmd_write, else READ.
  - READ:
    - wAddress=addr_reg; wByteEnable=be_reg.
    - wReadEnable = !rsp_valid || rsp_ready; this is the buffer-free condition.
    - Beat completes at an edge with wReadEnable=1: rsp_data<=wReadData, rsp_valid<=1, rsp_last<=(beats_left==0).
    - If that was the last beat go to IDLE; else addr_reg+=ADDR_STEP and beats_left-=1.
    - A held response with rsp_ready=0 stalls the bus (wReadEnable=0); addr_reg does not change.
  - WRITE:
    - wr_ready=1.
    - wWriteEnable=wr_valid; wWriteData=wr_valid?wr_data:0; wAddress=addr_reg; wByteEnable=be_reg.
    - Beat completes on an edge with wr_valid=1.
    - If last go to IDLE; else addr_reg+=ADDR_STEP and beats_left-=1.
    - wr_valid=0 inserts idle bus cycles.
- Response register:
  - rsp_valid clears at an edge with rsp_ready=1 unless a new beat is captured at that same edge.
  - The response may drain in IDLE after the burst ends.
  - A new command is accepted while the last response is still held; the first read of that command waits on the buffer-free rule.
- Throughput: 1 beat/clock with wr_valid held high (writes) or rsp_ready held high (reads).
  - An N-beat burst occupies exactly N bus cycles plus the 1 IDLE cycle for command acceptance.
- Address arithmetic: 32-bit modulo; 0xFFFFFFFC+4 wraps to 0x00000000 with no error.
- cmd_len=0: single beat; rsp_last=1 on it.
- Unmapped address: wReadData is captured as-is, no error signalling; a bus timeout is out of scope.
- wr_valid outside WRITE is ignored; wr_ready=0 there.

Test Plan:
- Single read: cmd read addr 0xFF200100, len 0, rsp_ready=1; bench responder returns 0x12345678.
  - Required: wReadEnable high exactly 1 cycle with wAddress=0xFF200100; next cycle rsp_valid=1, rsp_data=0x12345678, rsp_last=1; busy falls.
- Read burst len 3 from 0x100, responder returns addr+1, rsp_ready=1.
  - Required: 4 consecutive wReadEnable cycles at 0x100/0x104/0x108/0x10C; rsp_data 0x101,0x105,0x109,0x10D; rsp_last only on the 4th.
- Read backpressure: same burst with rsp_ready=0 for 5 cycles after the first response.
  - Required: wReadEnable low during the stall, wAddress held at 0x104, no beat lost or duplicated.
- Write burst len 2 to 0x200, be=4'b0011, wr_valid gapped as 1,0,1,1.
  - Required: wWriteEnable pattern 1,0,1,1; data/address pairs (D0,0x200),(D1,0x204),(D2,0x208); wByteEnable=0011 throughout; never both strobes high.
- Wrap: read len 1 at 0xFFFFFFFC.
  - Required: addresses 0xFFFFFFFC then 0x00000000.
- Async reset: assert iRST_n=0 mid write burst, off-edge.
  - Required: all bus outputs 0 immediately; after release cmd_ready=1 and busy=0; the next command runs normally.

Source files
------------

// File: rtl/io_bus_initiator_if.sv
// io_bus_initiator_if: groups the command, write-data, read-response and IO-bus signals of the
// IO-bus initiator.
//   master : the initiator's view; it takes commands and write data and drives the IO bus.
//   slave  : the view of the agent and responders around it.
// Signals:
//   cmd_*        command channel (valid/ready; write, addr, be, len = beats minus one)
//   wr_*         write-data channel (valid/ready, data)
//   rsp_*        read-response channel (valid/ready, data, last)
//   busy         high whenever a burst is in progress
//   w*           memory-mapped IO bus (read/write strobes, byte enable, address, data)
interface io_bus_initiator_if #(
    parameter int unsigned LEN_W = 4
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [31:0]      cmd_addr;
    logic [3:0]       cmd_be;
    logic [LEN_W-1:0] cmd_len;

    logic             wr_valid;
    logic [31:0]      wr_data;
    logic             wr_ready;

    logic             rsp_valid;
    logic [31:0]      rsp_data;
    logic             rsp_last;
    logic             rsp_ready;

    logic             busy;

    logic             wReadEnable;
    logic             wWriteEnable;
    logic [3:0]       wByteEnable;
    logic [31:0]      wAddress;
    logic [31:0]      wWriteData;
    logic [31:0]      wReadData;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_len,
        input  wr_valid, wr_data,
        input  rsp_ready,
        input  wReadData,
        output cmd_ready, wr_ready,
        output rsp_valid, rsp_data, rsp_last,
        output busy,
        output wReadEnable, wWriteEnable, wByteEnable, wAddress, wWriteData
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_len,
        output wr_valid, wr_data,
        output rsp_ready,
        output wReadData,
        input  cmd_ready, wr_ready,
        input  rsp_valid, rsp_data, rsp_last,
        input  busy,
        input  wReadEnable, wWriteEnable, wByteEnable, wAddress, wWriteData
    );
endinterface

// File: rtl/io_bus_initiator.sv
// io_bus_initiator: master-side engine for the memory-mapped IO bus. Turns single or burst
// read/write commands into IO-bus cycles, one beat per clock, so hardware agents can poll or
// program IO peripherals without the CPU. An external arbiter muxes it with the CPU's IO port.
// Ports:
//   iCLK    system clock, rising edge
//   iRST_n  asynchronous active-low reset
//   bus     io_bus_initiator_if.master: command, write-data and response channels, busy flag
//           and the IO bus itself (wReadEnable/wWriteEnable/wByteEnable/wAddress/wWriteData
//           out, wReadData in)
// Parameters:
//   LEN_W      width of cmd_len; a burst is cmd_len+1 beats
//   ADDR_STEP  byte increment of wAddress between beats (32-bit modulo)
module io_bus_initiator #(
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned ADDR_STEP = 4
) (
    input logic                   iCLK,
    input logic                   iRST_n,
    io_bus_initiator_if.master    bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite
    } state_e;

    state_e           state_q;
    logic [31:0]      addr_q;
    logic [3:0]       be_q;
    logic [LEN_W-1:0] beats_left_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_data_q;
    logic             rsp_last_q;

    // The single response register is free when empty or being drained at this edge; a read
    // beat may only go out on the bus then, so a stalled consumer stalls the bus.
    logic rd_fire;
    logic wr_fire;
    logic last_beat;

    always_comb begin
        rd_fire   = (state_q == StRead) && (!rsp_valid_q || bus.rsp_ready);
        wr_fire   = (state_q == StWrite) && bus.wr_valid;
        last_beat = (beats_left_q == '0);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            be_q         <= '0;
            beats_left_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_last_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        addr_q       <= bus.cmd_addr;
                        be_q         <= bus.cmd_be;
                        beats_left_q <= bus.cmd_len;
                        state_q      <= bus.cmd_write ? StWrite : StRead;
                    end
                end
                StRead: begin
                    if (rd_fire) begin
                        if (last_beat) begin
                            state_q <= StIdle;
                        end else begin
                            addr_q       <= addr_q + 32'(ADDR_STEP);
                            beats_left_q <= beats_left_q - LEN_W'(1);
                        end
                    end
                end
                StWrite: begin
                    if (wr_fire) begin
                        if (last_beat) begin
                            state_q <= StIdle;
                        end else begin
                            addr_q       <= addr_q + 32'(ADDR_STEP);
                            beats_left_q <= beats_left_q - LEN_W'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            // A capture at the same edge as a drain keeps the register full.
            if (rd_fire) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= bus.wReadData;
                rsp_last_q  <= last_beat;
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // Strobes follow the handshakes combinationally: the responders return read data in the
    // same cycle and sample writes at the closing edge.
    always_comb begin
        bus.cmd_ready    = (state_q == StIdle);
        bus.busy         = (state_q != StIdle);
        bus.wr_ready     = 1'b0;
        bus.wReadEnable  = 1'b0;
        bus.wWriteEnable = 1'b0;
        bus.wByteEnable  = '0;
        bus.wAddress     = addr_q;
        bus.wWriteData   = '0;
        bus.rsp_valid    = rsp_valid_q;
        bus.rsp_data     = rsp_data_q;
        bus.rsp_last     = rsp_last_q;
        unique case (state_q)
            StRead: begin
                bus.wReadEnable = rd_fire;
                bus.wByteEnable = be_q;
            end
            StWrite: begin
                bus.wr_ready     = 1'b1;
                bus.wWriteEnable = bus.wr_valid;
                bus.wWriteData   = bus.wr_valid ? bus.wr_data : 32'h0;
                bus.wByteEnable  = be_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_io_bus_initiator.sv
// tb_io_bus_initiator: directed bench for io_bus_initiator. A combinational responder returns
// either a fixed word or address+1; a monitor samples the bus just before each rising edge.
module tb_io_bus_initiator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_bus_initiator_if #(.LEN_W(4)) bus ();

    io_bus_initiator #(
        .LEN_W     (4),
        .ADDR_STEP (4)
    ) dut (
        .iCLK   (clk),
        .iRST_n (rst_n),
        .bus    (bus)
    );

    logic resp_mode = 1'b0;
    assign bus.wReadData = !bus.wReadEnable ? 32'hDEAD_BEEF :
                           (resp_mode ? bus.wAddress + 32'd1 : 32'h1234_5678);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Bus monitor, sampling 1 time unit before each rising edge.
    int          cyc     = 0;
    int          both_hi = 0;
    logic        log_en  = 1'b0;
    logic [31:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [31:0] rsp_data_q[$];
    logic        rsp_last_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [3:0]  wr_be_q[$];

    always @(negedge clk) begin
        #4;
        cyc++;
        if (bus.wReadEnable && bus.wWriteEnable) both_hi++;
        if (log_en) begin
            if (bus.wReadEnable) begin
                rd_addr_q.push_back(bus.wAddress);
                rd_cyc_q.push_back(cyc);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_data_q.push_back(bus.rsp_data);
                rsp_last_q.push_back(bus.rsp_last);
            end
            if (bus.wWriteEnable) begin
                wr_addr_q.push_back(bus.wAddress);
                wr_data_q.push_back(bus.wWriteData);
                wr_be_q.push_back(bus.wByteEnable);
            end
        end
    end

    task automatic clear_logs();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        rsp_data_q.delete();
        rsp_last_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_be_q.delete();
    endtask

    // Offers a command for one cycle; returns at the falling edge of the first bus cycle.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [3:0] len);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_be    = be;
        bus.cmd_len   = len;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, " idle"}, 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reads(input string tag, input int n, input logic [31:0] a[4],
                               input logic [31:0] d[4], input logic l[4]);
        check({tag, " rd count"}, 32'(rd_addr_q.size()), 32'(n));
        check({tag, " rsp count"}, 32'(rsp_data_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s addr%0d", tag, i),
                  (i < rd_addr_q.size()) ? rd_addr_q[i] : 32'hxxxx_xxxx, a[i]);
            check($sformatf("%s data%0d", tag, i),
                  (i < rsp_data_q.size()) ? rsp_data_q[i] : 32'hxxxx_xxxx, d[i]);
            check($sformatf("%s last%0d", tag, i),
                  (i < rsp_last_q.size()) ? 32'(rsp_last_q[i]) : 32'hxxxx_xxxx, 32'(l[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] ea[4];
        logic [31:0] ed[4];
        logic        el[4];
        int          span;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_be    = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst wRE", 32'(bus.wReadEnable), 32'd0);
        check("rst wWE", 32'(bus.wWriteEnable), 32'd0);
        check("rst wBE", 32'(bus.wByteEnable), 32'd0);
        check("rst wAddress", bus.wAddress, 32'd0);
        check("rst wWriteData", bus.wWriteData, 32'd0);
        check("rst wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst rsp_data", bus.rsp_data, 32'd0);
        check("rst rsp_last", 32'(bus.rsp_last), 32'd0);

        // Single read
        log_en        = 1'b1;
        bus.rsp_ready = 1'b1;
        resp_mode     = 1'b0;
        clear_logs();
        issue(1'b0, 32'hFF20_0100, 4'hF, 4'd0);
        #1;
        check("single wRE", 32'(bus.wReadEnable), 32'd1);
        check("single wAddress", bus.wAddress, 32'hFF20_0100);
        check("single wBE", 32'(bus.wByteEnable), 32'hF);
        check("single busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        #1;
        check("single wRE off", 32'(bus.wReadEnable), 32'd0);
        check("single rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("single rsp_data", bus.rsp_data, 32'h1234_5678);
        check("single rsp_last", 32'(bus.rsp_last), 32'd1);
        check("single busy off", 32'(bus.busy), 32'd0);
        @(negedge clk);
        #1;
        check("single rd count", 32'(rd_addr_q.size()), 32'd1);
        check("single rsp drained", 32'(bus.rsp_valid), 32'd0);

        // Read burst, len 3
        resp_mode = 1'b1;
        clear_logs();
        issue(1'b0, 32'h100, 4'hF, 4'd3);
        wait_idle("burst");
        ea = '{32'h100, 32'h104, 32'h108, 32'h10C};
        ed = '{32'h101, 32'h105, 32'h109, 32'h10D};
        el = '{1'b0, 1'b0, 1'b0, 1'b1};
        check_reads("burst", 4, ea, ed, el);
        span = (rd_cyc_q.size() >= 4) ? rd_cyc_q[3] - rd_cyc_q[0] : -1;
        check("burst consecutive", 32'(span), 32'd3);

        // Read backpressure: consumer stalls 5 cycles after the first response
        clear_logs();
        issue(1'b0, 32'h100, 4'hF, 4'd3);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        repeat (5) begin
            #1;
            check("stall wRE", 32'(bus.wReadEnable), 32'd0);
            check("stall wAddress", bus.wAddress, 32'h104);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        wait_idle("bp");
        check_reads("bp", 4, ea, ed, el);

        // Gapped write burst, len 2
        clear_logs();
        issue(1'b1, 32'h200, 4'b0011, 4'd2);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hA0A0_0000;
        #1;
        check("wr c0 wWE", 32'(bus.wWriteEnable), 32'd1);
        check("wr c0 wr_ready", 32'(bus.wr_ready), 32'd1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.wr_data  = 32'hFFFF_FFFF;
        #1;
        check("wr c1 wWE", 32'(bus.wWriteEnable), 32'd0);
        check("wr c1 wWriteData", bus.wWriteData, 32'd0);
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hA1A1_1111;
        #1;
        check("wr c2 wWE", 32'(bus.wWriteEnable), 32'd1);
        @(negedge clk);
        bus.wr_data  = 32'hA2A2_2222;
        #1;
        check("wr c3 wWE", 32'(bus.wWriteEnable), 32'd1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        #1;
        check("wr done busy", 32'(bus.busy), 32'd0);
        check("wr done wr_ready", 32'(bus.wr_ready), 32'd0);
        check("wr count", 32'(wr_addr_q.size()), 32'd3);
        ea = '{32'h200, 32'h204, 32'h208, 32'h0};
        ed = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'h0};
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wr addr%0d", i),
                  (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hxxxx_xxxx, ea[i]);
            check($sformatf("wr data%0d", i),
                  (i < wr_data_q.size()) ? wr_data_q[i] : 32'hxxxx_xxxx, ed[i]);
            check($sformatf("wr be%0d", i),
                  (i < wr_be_q.size()) ? 32'(wr_be_q[i]) : 32'hxxxx_xxxx, 32'b0011);
        end

        // Address wrap
        clear_logs();
        issue(1'b0, 32'hFFFF_FFFC, 4'hF, 4'd1);
        wait_idle("wrap");
        ea = '{32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0};
        ed = '{32'hFFFF_FFFD, 32'h1, 32'h0, 32'h0};
        el = '{1'b0, 1'b1, 1'b0, 1'b0};
        check_reads("wrap", 2, ea, ed, el);

        // Asynchronous reset mid write burst
        clear_logs();
        issue(1'b1, 32'h300, 4'hF, 4'd3);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h5555_0000;
        @(negedge clk);
        bus.wr_data  = 32'h5555_1111;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst wWE", 32'(bus.wWriteEnable), 32'd0);
        check("arst wRE", 32'(bus.wReadEnable), 32'd0);
        check("arst wAddress", bus.wAddress, 32'd0);
        check("arst wWriteData", bus.wWriteData, 32'd0);
        check("arst wBE", 32'(bus.wByteEnable), 32'd0);
        check("arst wr_ready", 32'(bus.wr_ready), 32'd0);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        rst_n        = 1'b1;
        #1;
        check("arst cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("arst busy", 32'(bus.busy), 32'd0);
        check("arst wr count", 32'(wr_addr_q.size()), 32'd1);
        clear_logs();
        issue(1'b0, 32'h40, 4'hF, 4'd0);
        wait_idle("post");
        ea = '{32'h40, 32'h0, 32'h0, 32'h0};
        ed = '{32'h41, 32'h0, 32'h0, 32'h0};
        el = '{1'b1, 1'b0, 1'b0, 1'b0};
        check_reads("post", 1, ea, ed, el);

        check("never both strobes", 32'(both_hi), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
